// File: rtl/count_zeros_sequencer.sv
// count_zeros_sequencer: multi-cycle CLZ / CTZ / CPOP engine for a 32-bit operand.
// Scans one CHUNK_W-bit slice per cycle. CLZ and CTZ stop early at the first
// nonzero slice. The result is held until the consumer takes it.
module count_zeros_sequencer #(
  parameter int CHUNK_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_operand,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [5:0]  resp_result,
  output logic        resp_zero,
  output logic        resp_err,
  output logic        busy
);

  localparam int NUM_CHUNKS = 32 / CHUNK_W;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_CLZ  = 2'b00;
  localparam logic [1:0] OP_CTZ  = 2'b01;
  localparam logic [1:0] OP_CPOP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [5:0]       CHUNK_CNT = 6'(CHUNK_W);

  // Leading zeros inside one slice (CHUNK_W when the slice is all zeros).
  function automatic logic [5:0] chunk_lz(input logic [CHUNK_W-1:0] c);
    logic [5:0] n;
    logic       hit;
    n   = 6'd0;
    hit = 1'b0;
    for (int i = CHUNK_W - 1; i >= 0; i--) begin
      if (hit || c[i]) begin
        hit = 1'b1;
      end else begin
        n = n + 6'd1;
      end
    end
    return n;
  endfunction

  // Trailing zeros inside one slice (CHUNK_W when the slice is all zeros).
  function automatic logic [5:0] chunk_tz(input logic [CHUNK_W-1:0] c);
    logic [5:0] n;
    logic       hit;
    n   = 6'd0;
    hit = 1'b0;
    for (int i = 0; i < CHUNK_W; i++) begin
      if (hit || c[i]) begin
        hit = 1'b1;
      end else begin
        n = n + 6'd1;
      end
    end
    return n;
  endfunction

  // Number of set bits inside one slice.
  function automatic logic [5:0] chunk_pop(input logic [CHUNK_W-1:0] c);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < CHUNK_W; i++) begin
      n = n + {5'd0, c[i]};
    end
    return n;
  endfunction

  logic [1:0]         state_r;
  logic [1:0]         op_r;
  logic [31:0]        operand_r;
  logic [5:0]         count_r;
  logic [IDX_W-1:0]   idx_r;
  logic               resp_valid_r;
  logic [5:0]         resp_result_r;
  logic               resp_zero_r;
  logic               resp_err_r;
  logic               busy_r;

  logic [IDX_W-1:0]   chunk_pos_s;
  logic [31:0]        shamt_s;
  logic [CHUNK_W-1:0] chunk_s;
  logic               chunk_zero_s;
  logic               last_s;
  logic [5:0]         inc_s;
  logic               stop_s;
  logic [5:0]         next_count_s;

  assign req_ready   = (state_r == S_IDLE) && !rst;
  assign resp_valid  = resp_valid_r;
  assign resp_result = resp_result_r;
  assign resp_zero   = resp_zero_r;
  assign resp_err    = resp_err_r;
  assign busy        = busy_r;

  // Select the current slice and work out its count contribution and whether the scan ends.
  always_comb begin
    chunk_pos_s  = (op_r == OP_CLZ) ? (LAST_IDX - idx_r) : idx_r;
    shamt_s      = 32'(chunk_pos_s) * 32'(CHUNK_W);
    chunk_s      = CHUNK_W'(operand_r >> shamt_s);
    chunk_zero_s = (chunk_s == {CHUNK_W{1'b0}});
    last_s       = (idx_r == LAST_IDX);
    inc_s        = 6'd0;
    stop_s       = 1'b1;
    case (op_r)
      OP_CLZ: begin
        if (chunk_zero_s) begin
          inc_s  = CHUNK_CNT;
          stop_s = last_s;
        end else begin
          inc_s  = chunk_lz(chunk_s);
          stop_s = 1'b1;
        end
      end
      OP_CTZ: begin
        if (chunk_zero_s) begin
          inc_s  = CHUNK_CNT;
          stop_s = last_s;
        end else begin
          inc_s  = chunk_tz(chunk_s);
          stop_s = 1'b1;
        end
      end
      OP_CPOP: begin
        inc_s  = chunk_pop(chunk_s);
        stop_s = last_s;
      end
      default: begin
        inc_s  = 6'd0;
        stop_s = 1'b1;
      end
    endcase
    next_count_s = count_r + inc_s;
  end

  // Control FSM plus operand, count and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      op_r          <= 2'b00;
      operand_r     <= 32'd0;
      count_r       <= 6'd0;
      idx_r         <= {IDX_W{1'b0}};
      resp_valid_r  <= 1'b0;
      resp_result_r <= 6'd0;
      resp_zero_r   <= 1'b0;
      resp_err_r    <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            operand_r   <= req_operand;
            op_r        <= req_op;
            count_r     <= 6'd0;
            idx_r       <= {IDX_W{1'b0}};
            resp_zero_r <= (req_operand == 32'd0);
            busy_r      <= 1'b1;
            if (req_op == OP_RSVD) begin
              // Reserved op skips the scan and reports an error straight away.
              state_r       <= S_DONE;
              resp_result_r <= 6'd0;
              resp_err_r    <= 1'b1;
              resp_valid_r  <= 1'b1;
            end else begin
              state_r    <= S_SCAN;
              resp_err_r <= 1'b0;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_SCAN: begin
          count_r <= next_count_s;
          if (stop_s) begin
            state_r       <= S_DONE;
            resp_result_r <= next_count_s;
            resp_valid_r  <= 1'b1;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            state_r      <= S_IDLE;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
          end else begin
            state_r <= S_DONE;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_zeros_sequencer.sv
// Directed testbench for count_zeros_sequencer. Three instances (CHUNK_W = 8, 1, 32)
// share stimulus; sel routes req_valid to one instance and muxes its outputs back.
module tb_count_zeros_sequencer;

  localparam logic [1:0] OP_CLZ  = 2'b00;
  localparam logic [1:0] OP_CTZ  = 2'b01;
  localparam logic [1:0] OP_CPOP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef struct {
    int          w;    // 0: CHUNK_W=8, 1: CHUNK_W=1, 2: CHUNK_W=32
    logic [1:0]  op;
    logic [31:0] opd;
    int          k;    // scan cycles
    logic [5:0]  r;
    logic        z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_operand = 32'd0;
  logic        resp_ready = 1'b1;
  int          sel = 0;
  int          tests = 0;
  int          failed = 0;

  logic        rv_8, rv_1, rv_32;
  logic        rr_8, rr_1, rr_32;
  logic        vl_8, vl_1, vl_32;
  logic [5:0]  rs_8, rs_1, rs_32;
  logic        zo_8, zo_1, zo_32;
  logic        er_8, er_1, er_32;
  logic        bz_8, bz_1, bz_32;

  logic        req_ready, resp_valid, resp_zero, resp_err, busy;
  logic [5:0]  resp_result;

  assign rv_8  = req_valid && (sel == 0);
  assign rv_1  = req_valid && (sel == 1);
  assign rv_32 = req_valid && (sel == 2);

  always #5 clk = ~clk;

  count_zeros_sequencer #(.CHUNK_W(8)) dut8 (
    .clk(clk), .rst(rst), .req_valid(rv_8), .req_ready(rr_8), .req_op(req_op),
    .req_operand(req_operand), .resp_valid(vl_8), .resp_ready(resp_ready),
    .resp_result(rs_8), .resp_zero(zo_8), .resp_err(er_8), .busy(bz_8));

  count_zeros_sequencer #(.CHUNK_W(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv_1), .req_ready(rr_1), .req_op(req_op),
    .req_operand(req_operand), .resp_valid(vl_1), .resp_ready(resp_ready),
    .resp_result(rs_1), .resp_zero(zo_1), .resp_err(er_1), .busy(bz_1));

  count_zeros_sequencer #(.CHUNK_W(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid(rv_32), .req_ready(rr_32), .req_op(req_op),
    .req_operand(req_operand), .resp_valid(vl_32), .resp_ready(resp_ready),
    .resp_result(rs_32), .resp_zero(zo_32), .resp_err(er_32), .busy(bz_32));

  // Route the selected instance's outputs to the common observation signals.
  always_comb begin
    case (sel)
      1: {req_ready, resp_valid, resp_result, resp_zero, resp_err, busy} = {rr_1, vl_1, rs_1, zo_1, er_1, bz_1};
      2: {req_ready, resp_valid, resp_result, resp_zero, resp_err, busy} = {rr_32, vl_32, rs_32, zo_32, er_32, bz_32};
      default: {req_ready, resp_valid, resp_result, resp_zero, resp_err, busy} = {rr_8, vl_8, rs_8, zo_8, er_8, bz_8};
    endcase
  end

  // One full transaction with resp_ready held high. Called #1 after a rising edge
  // with the selected instance idle; returns #1 after the handshake edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] opd, output int lat,
                        output logic [5:0] res, output logic z, output logic e,
                        output logic busy_v, output logic busy_end);
    resp_ready  = 1'b1;
    req_op      = op;
    req_operand = opd;
    req_valid   = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res    = resp_result;
    z      = resp_zero;
    e      = resp_err;
    busy_v = busy;
    @(posedge clk); #1;
    busy_end = busy;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    sel = 0;
    #2;
    got = {req_ready, busy, resp_valid, resp_result == 6'd0 ? 1'b0 : 1'b1, resp_zero, resp_err, 1'b0};
    tests++;
    if (got !== 7'd0) begin
      failed++;
      $display("FAIL reset_state: got ready/busy/valid/res!=0/zero/err=%b, expected 0000000", got);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_release_ready: got %b, expected 1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors(input string name, input vec_t v[$]);
    int lat;
    logic [5:0] res;
    logic z, e, bv, be;
    logic [16:0] got, exp;
    foreach (v[i]) begin
      sel = v[i].w;
      run_op(v[i].op, v[i].opd, lat, res, z, e, bv, be);
      got = {lat[7:0], res, z, e, bv, be};
      exp = {v[i].k[7:0], v[i].r, v[i].z, 1'b0, 1'b1, 1'b0};
      tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL %s[%0d]: got lat=%0d res=%0d zero=%b err=%b busy=%b busy_after=%b, expected lat=%0d res=%0d zero=%b err=0 busy=1 busy_after=0",
                 name, i, lat, res, z, e, bv, be, v[i].k, v[i].r, v[i].z);
      end
    end
    sel = 0;
  endtask

  task automatic test_clz_early();
    vec_t v[$];
    v.push_back('{0, OP_CLZ, 32'h0001_0000, 2, 6'd15, 1'b0});
    v.push_back('{0, OP_CLZ, 32'h8000_0000, 1, 6'd0, 1'b0});
    v.push_back('{0, OP_CLZ, 32'h0000_0010, 4, 6'd27, 1'b0});
    test_vectors("clz", v);
  endtask

  task automatic test_ctz();
    vec_t v[$];
    v.push_back('{0, OP_CTZ, 32'h8000_0000, 4, 6'd31, 1'b0});
    v.push_back('{0, OP_CTZ, 32'h0000_0001, 1, 6'd0, 1'b0});
    v.push_back('{0, OP_CTZ, 32'h0001_0000, 3, 6'd16, 1'b0});
    test_vectors("ctz", v);
  endtask

  task automatic test_cpop();
    vec_t v[$];
    v.push_back('{0, OP_CPOP, 32'hF0F0_00FF, 4, 6'd16, 1'b0});
    v.push_back('{0, OP_CPOP, 32'hFFFF_FFFF, 4, 6'd32, 1'b0});
    v.push_back('{0, OP_CPOP, 32'h8000_0001, 4, 6'd2, 1'b0});
    test_vectors("cpop", v);
  endtask

  task automatic test_zero_operand();
    vec_t v[$];
    v.push_back('{0, OP_CLZ,  32'h0, 4,  6'd32, 1'b1});
    v.push_back('{0, OP_CTZ,  32'h0, 4,  6'd32, 1'b1});
    v.push_back('{0, OP_CPOP, 32'h0, 4,  6'd0,  1'b1});
    v.push_back('{1, OP_CLZ,  32'h0, 32, 6'd32, 1'b1});
    v.push_back('{1, OP_CTZ,  32'h0, 32, 6'd32, 1'b1});
    v.push_back('{2, OP_CLZ,  32'h0, 1,  6'd32, 1'b1});
    v.push_back('{2, OP_CTZ,  32'h0, 1,  6'd32, 1'b1});
    test_vectors("zero", v);
  endtask

  task automatic test_chunk_widths();
    vec_t v[$];
    v.push_back('{1, OP_CLZ,  32'h0001_0000, 16, 6'd15, 1'b0});
    v.push_back('{1, OP_CTZ,  32'h0000_0100, 9,  6'd8,  1'b0});
    v.push_back('{1, OP_CPOP, 32'hF0F0_00FF, 32, 6'd16, 1'b0});
    v.push_back('{2, OP_CLZ,  32'h0001_0000, 1,  6'd15, 1'b0});
    v.push_back('{2, OP_CTZ,  32'h8000_0000, 1,  6'd31, 1'b0});
    v.push_back('{2, OP_CPOP, 32'hF0F0_00FF, 1,  6'd16, 1'b0});
    test_vectors("width", v);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [10:0] got;
    sel = 0;
    resp_ready  = 1'b0;
    req_op      = OP_CTZ;
    req_operand = 32'h0000_0100;
    req_valid   = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (lat != 2) begin
      failed++;
      $display("FAIL bp_latency: got %0d, expected 2", lat);
    end
    // A competing request is offered while the response is stalled.
    req_op      = OP_CPOP;
    req_operand = 32'hFFFF_FFFF;
    req_valid   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      got = {resp_result, resp_zero, resp_err, req_ready, resp_valid, busy};
      tests++;
      if (got !== {6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
        failed++;
        $display("FAIL bp_hold[%0d]: got res=%0d zero=%b err=%b ready=%b valid=%b busy=%b, expected res=8 zero=0 err=0 ready=0 valid=1 busy=1",
                 c, got[10:5], got[4], got[3], got[2], got[1], got[0]);
      end
      @(posedge clk); #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({resp_valid, busy, req_ready} !== 3'b001) begin
      failed++;
      $display("FAIL bp_release: got valid/busy/ready=%b, expected 001", {resp_valid, busy, req_ready});
    end
  endtask

  task automatic test_reserved_op();
    int lat;
    logic [5:0] res;
    logic z, e, bv, be;
    sel = 0;
    run_op(OP_RSVD, 32'h1234_5678, lat, res, z, e, bv, be);
    tests++;
    if ({lat[7:0], res, z, e, bv, be} !== {8'd0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL reserved_op: got lat=%0d res=%0d zero=%b err=%b busy=%b busy_after=%b, expected lat=0 res=0 zero=0 err=1 busy=1 busy_after=0",
               lat, res, z, e, bv, be);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    logic [5:0] res;
    logic z, e, bv, be;
    sel = 0;
    resp_ready  = 1'b1;
    req_op      = OP_CPOP;
    req_operand = 32'hFFFF_FFFF;
    req_valid   = 1'b1;
    @(posedge clk); #1;   // after E0: first SCAN cycle
    req_valid = 1'b0;
    @(posedge clk); #1;   // after E1: second SCAN cycle
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, resp_valid, req_ready} !== 3'b000) begin
      failed++;
      $display("FAIL rst_mid_scan: got busy/valid/ready=%b, expected 000", {busy, resp_valid, req_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      failed++;
      $display("FAIL rst_mid_ready: got %b, expected 1", req_ready);
    end
    run_op(OP_CLZ, 32'h00FF_0000, lat, res, z, e, bv, be);
    tests++;
    if ({lat[7:0], res, z, e, bv, be} !== {8'd2, 6'd8, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL rst_mid_after: got lat=%0d res=%0d zero=%b err=%b busy=%b busy_after=%b, expected lat=2 res=8 zero=0 err=0 busy=1 busy_after=0",
               lat, res, z, e, bv, be);
    end
  endtask

  initial begin
    test_reset();
    test_clz_early();
    test_ctz();
    test_cpop();
    test_zero_operand();
    test_chunk_widths();
    test_backpressure();
    test_reserved_op();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
